// File: rtl/seq_pkg.sv
// seq_pkg: state encoding, instruction class codes and the control word
// shared by the control sequencer and its decoder.
package seq_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Instruction class, IR[15:14]
  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LDI  = 2'b01;
  localparam logic [1:0] CLS_MEM  = 2'b10;
  localparam logic [1:0] CLS_FLOW = 2'b11;

  // FLOW sub-operation, IR[13:12]
  localparam logic [1:0] FLOW_JMP  = 2'b00;
  localparam logic [1:0] FLOW_BZ   = 2'b01;
  localparam logic [1:0] FLOW_BN   = 2'b10;
  localparam logic [1:0] FLOW_HALT = 2'b11;

  // Function-unit codes used by the sequencer itself
  localparam logic [3:0] DEF_FS_PASS_A = 4'b0000;
  localparam logic [3:0] DEF_FS_PASS_B = 4'b1100;

  // Everything the sequencer drives toward the datapath and the memories
  typedef struct packed {
    logic       rw;
    logic       mb;
    logic       md;
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic [3:0] fs;
    logic [7:0] const_val;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // An 8-bit add of the raw offset is the same as adding its sign extension
  // and discarding the carry, which gives the modulo-256 wrap for free.
  function automatic logic [7:0] branch_target(input logic [7:0] pc_now,
                                               input logic [7:0] offset);
    return pc_now + offset;
  endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: purely combinational translation of the sequencer state
// and the instruction register into the datapath/memory control word.
module control_decode
  import seq_pkg::*;
#(
  parameter logic [3:0] FS_PASS_A = DEF_FS_PASS_A,
  parameter logic [3:0] FS_PASS_B = DEF_FS_PASS_B
) (
  input  state_t      state,
  input  logic [15:0] ir,
  input  logic        dmem_ack,
  output ctrl_t       ctrl
);

  logic  is_store;
  logic  unused_ir0;
  ctrl_t mem_ctrl;

  assign is_store   = ir[13];
  assign unused_ir0 = ir[0];

  // Operand selects for a memory transfer, held from EXEC through the MEM wait cycles
  always_comb begin
    mem_ctrl    = CTRL_IDLE;
    mem_ctrl.aa = ir[6:4];
    if (is_store) begin
      mem_ctrl.ba = ir[3:1];
    end else begin
      mem_ctrl.da = ir[9:7];
      mem_ctrl.md = 1'b1;
    end
  end

  // Control word selected by state; RW is only raised for ALU/LDI in EXEC and a load's ack cycle
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      FETCH: begin
        ctrl.imem_req = 1'b1;
      end
      EXEC: begin
        case (ir[15:14])
          CLS_ALU: begin
            ctrl.da = ir[9:7];
            ctrl.aa = ir[6:4];
            ctrl.ba = ir[3:1];
            ctrl.fs = ir[13:10];
            ctrl.rw = 1'b1;
          end
          CLS_LDI: begin
            ctrl.da        = ir[10:8];
            ctrl.const_val = ir[7:0];
            ctrl.fs        = FS_PASS_B;
            ctrl.mb        = 1'b1;
            ctrl.rw        = 1'b1;
          end
          CLS_MEM: begin
            ctrl = mem_ctrl;
          end
          CLS_FLOW: begin
            ctrl.aa = ir[10:8];
            if (ir[13:12] == FLOW_BZ || ir[13:12] == FLOW_BN) begin
              ctrl.fs = FS_PASS_A;
            end
          end
          default: begin
            ctrl = CTRL_IDLE;
          end
        endcase
      end
      MEM: begin
        ctrl          = mem_ctrl;
        ctrl.dmem_req = 1'b1;
        ctrl.dmem_we  = is_store;
        ctrl.rw       = ~is_store & dmem_ack;
      end
      HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        ctrl = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute controller for the 8-register datapath.
// Holds the FSM, pc, IR and both handshakes; decoding lives in control_decode.
module control_sequencer
  import seq_pkg::*;
#(
  parameter logic [3:0] FS_PASS_A = DEF_FS_PASS_A,
  parameter logic [3:0] FS_PASS_B = DEF_FS_PASS_B
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        RW,
  output logic        MB,
  output logic        MD,
  output logic [2:0]  DA,
  output logic [2:0]  AA,
  output logic [2:0]  BA,
  output logic [3:0]  FS,
  output logic [7:0]  const_out,
  input  logic        V,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  output logic [7:0]  pc,
  output logic        halted
);

  state_t      state;
  logic [15:0] ir;
  ctrl_t       ctrl;
  logic        branch_taken;
  logic        unused_flags;

  // Overflow and carry do not steer any branch
  assign unused_flags = V ^ C;

  control_decode #(
    .FS_PASS_A(FS_PASS_A),
    .FS_PASS_B(FS_PASS_B)
  ) u_decode (
    .state   (state),
    .ir      (ir),
    .dmem_ack(dmem_ack),
    .ctrl    (ctrl)
  );

  // Branch condition from the live flags; only consumed while in EXEC
  always_comb begin
    branch_taken = 1'b0;
    if (ir[15:14] == CLS_FLOW) begin
      case (ir[13:12])
        FLOW_JMP: branch_taken = 1'b1;
        FLOW_BZ:  branch_taken = Z;
        FLOW_BN:  branch_taken = N;
        default:  branch_taken = 1'b0;
      endcase
    end
  end

  // Sequencer FSM: fetch handshake, one-cycle execute, data-memory wait, halt
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= 8'h00;
      ir    <= 16'h0000;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_data;
            pc    <= pc + 8'd1;
            state <= EXEC;
          end
        end
        EXEC: begin
          case (ir[15:14])
            CLS_MEM: begin
              state <= MEM;
            end
            CLS_FLOW: begin
              if (branch_taken) begin
                pc <= branch_target(pc, ir[7:0]);
              end
              state <= (ir[13:12] == FLOW_HALT) ? HALT : FETCH;
            end
            default: begin
              state <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (dmem_ack) begin
            state <= FETCH;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign imem_addr = pc;
  assign imem_req  = ctrl.imem_req;
  assign dmem_req  = ctrl.dmem_req;
  assign dmem_we   = ctrl.dmem_we;
  assign RW        = ctrl.rw;
  assign MB        = ctrl.mb;
  assign MD        = ctrl.md;
  assign DA        = ctrl.da;
  assign AA        = ctrl.aa;
  assign BA        = ctrl.ba;
  assign FS        = ctrl.fs;
  assign const_out = ctrl.const_val;
  assign halted    = ctrl.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table of single instructions plus hand-built
// sequences for data-memory waits, reset during an access and HALT.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        RW, MB, MD;
  logic [2:0]  DA, AA, BA;
  logic [3:0]  FS;
  logic [7:0]  const_out;
  logic        V, C, N, Z;
  logic [7:0]  pc;
  logic        halted;
  logic [27:0] dut_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .RW(RW), .MB(MB), .MD(MD), .DA(DA), .AA(AA), .BA(BA), .FS(FS), .const_out(const_out),
    .V(V), .C(C), .N(N), .Z(Z), .pc(pc), .halted(halted)
  );

  assign dut_word = {RW, MB, MD, DA, AA, BA, FS, const_out, dmem_req, dmem_we, imem_req, halted};

  typedef struct {
    string       name;
    logic [27:0] word;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        z;
    logic        n;
    logic [27:0] word;
    logic [7:0]  pc_after;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  function automatic logic [27:0] w(input logic rw, input logic mb, input logic md,
                                    input logic [2:0] da, input logic [2:0] aa, input logic [2:0] ba,
                                    input logic [3:0] fs, input logic [7:0] cst,
                                    input logic dreq, input logic dwe, input logic ireq, input logic hlt);
    return {rw, mb, md, da, aa, ba, fs, cst, dreq, dwe, ireq, hlt};
  endfunction

  function automatic logic [15:0] alu_i(input logic [3:0] fs, input logic [2:0] dr,
                                        input logic [2:0] sa, input logic [2:0] sb);
    return {2'b00, fs, dr, sa, sb, 1'b0};
  endfunction

  function automatic logic [15:0] ldi_i(input logic [2:0] dr, input logic [7:0] imm);
    return {2'b01, 3'b000, dr, imm};
  endfunction

  function automatic logic [15:0] mem_i(input logic st, input logic [2:0] dr,
                                        input logic [2:0] sa, input logic [2:0] sb);
    return {2'b10, st, 3'b000, dr, sa, sb, 1'b0};
  endfunction

  function automatic logic [15:0] flow_i(input logic [1:0] op, input logic [2:0] aa, input logic [7:0] off);
    return {2'b11, op, 1'b0, aa, off};
  endfunction

  function automatic vec_t mk_vec(input string name, input logic [15:0] instr, input logic z,
                                  input logic n, input logic [27:0] word, input logic [7:0] pc_after);
    vec_t v;
    v.name = name; v.instr = instr; v.z = z; v.n = n; v.word = word; v.pc_after = pc_after;
    return v;
  endfunction

  logic [27:0] fetch_w;
  logic [27:0] halt_w;

  task automatic expectWord(input string name, input logic [27:0] word);
    exp_t e;
    e.name = name;
    e.word = word;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard-empty: DUT word %h with nothing expected", dut_word);
    end else begin
      e = exp_q.pop_front();
      if (dut_word !== e.word) begin
        errors++;
        $display("[TB] FAIL %s: got word %h, expected %h", e.name, dut_word, e.word);
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT in FETCH; leaves it at the next FETCH negedge
  task automatic applyStimulus(input vec_t v);
    imem_data = v.instr;
    imem_ack  = 1'b1;
    Z = v.z;
    N = v.n;
    expectWord({v.name, "-fetch"}, fetch_w);
    checkOutput();
    expectWord({v.name, "-exec"}, v.word);
    @(negedge clk);
    imem_ack = 1'b0;
    checkOutput();
    @(negedge clk);
    expectWord({v.name, "-refetch"}, fetch_w);
    checkOutput();
    checkValue({v.name, "-pc"}, pc, v.pc_after);
    Z = 1'b0;
    N = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int req_cycles;

    fetch_w = w(0, 0, 0, 3'd0, 3'd0, 3'd0, 4'h0, 8'h00, 0, 0, 1, 0);
    halt_w  = w(0, 0, 0, 3'd0, 3'd0, 3'd0, 4'h0, 8'h00, 0, 0, 0, 1);

    // pc before each row: 00,01,02,03,04,09,0A,FE,02,FE,FF,00
    vecs.push_back(mk_vec("add", alu_i(4'h2, 3'd3, 3'd1, 3'd2), 0, 0,
                          w(1, 0, 0, 3'd3, 3'd1, 3'd2, 4'h2, 8'h00, 0, 0, 0, 0), 8'h01));
    vecs.push_back(mk_vec("ldi", ldi_i(3'd5, 8'hA7), 0, 0,
                          w(1, 1, 0, 3'd5, 3'd0, 3'd0, 4'hC, 8'hA7, 0, 0, 0, 0), 8'h02));
    vecs.push_back(mk_vec("alu2", alu_i(4'h5, 3'd7, 3'd6, 3'd0), 0, 0,
                          w(1, 0, 0, 3'd7, 3'd6, 3'd0, 4'h5, 8'h00, 0, 0, 0, 0), 8'h03));
    vecs.push_back(mk_vec("bz-not", flow_i(2'b01, 3'd4, 8'h10), 0, 1,
                          w(0, 0, 0, 3'd0, 3'd4, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0), 8'h04));
    vecs.push_back(mk_vec("bn-taken", flow_i(2'b10, 3'd1, 8'h04), 0, 1,
                          w(0, 0, 0, 3'd0, 3'd1, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0), 8'h09));
    vecs.push_back(mk_vec("bn-not", flow_i(2'b10, 3'd2, 8'h04), 1, 0,
                          w(0, 0, 0, 3'd0, 3'd2, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0), 8'h0A));
    vecs.push_back(mk_vec("jmp-back", flow_i(2'b00, 3'd0, 8'hF3), 0, 0,
                          w(0, 0, 0, 3'd0, 3'd0, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0), 8'hFE));
    vecs.push_back(mk_vec("bz-wrap", flow_i(2'b01, 3'd2, 8'h03), 1, 0,
                          w(0, 0, 0, 3'd0, 3'd2, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0), 8'h02));
    vecs.push_back(mk_vec("jmp-fe", flow_i(2'b00, 3'd0, 8'hFB), 0, 0,
                          w(0, 0, 0, 3'd0, 3'd0, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0), 8'hFE));
    vecs.push_back(mk_vec("bz-fe-not", flow_i(2'b01, 3'd2, 8'h03), 0, 0,
                          w(0, 0, 0, 3'd0, 3'd2, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0), 8'hFF));
    vecs.push_back(mk_vec("alu-pcwrap", alu_i(4'hF, 3'd1, 3'd2, 3'd3), 0, 0,
                          w(1, 0, 0, 3'd1, 3'd2, 3'd3, 4'hF, 8'h00, 0, 0, 0, 0), 8'h00));
    vecs.push_back(mk_vec("ldi-hibits", {2'b01, 3'b101, 3'd6, 8'h3C}, 0, 0,
                          w(1, 1, 0, 3'd6, 3'd0, 3'd0, 4'hC, 8'h3C, 0, 0, 0, 0), 8'h01));

    imem_ack = 1'b0; imem_data = 16'h0000; dmem_ack = 1'b0;
    V = 1'b0; C = 1'b0; N = 1'b0; Z = 1'b0;

    doReset();
    expectWord("reset", fetch_w);
    checkOutput();
    checkValue("reset-pc", pc, 8'h00);
    checkValue("reset-imem_addr", imem_addr, 8'h00);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Load at pc=01 with three wait cycles; stray imem_ack must be ignored
    req_cycles = 0;
    imem_data = mem_i(1'b0, 3'd4, 3'd6, 3'd0);
    imem_ack  = 1'b1;
    @(negedge clk);
    expectWord("load-exec", w(0, 0, 1, 3'd4, 3'd6, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0));
    checkOutput();
    if (dmem_req === 1'b1) req_cycles++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_ack = (i == 3);
      if (i == 3) imem_ack = 1'b0;
      #1;
      if (dmem_req === 1'b1) req_cycles++;
      expectWord($sformatf("load-mem%0d", i),
                 w((i == 3), 0, 1, 3'd4, 3'd6, 3'd0, 4'h0, 8'h00, 1, 0, 0, 0));
      checkOutput();
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    if (dmem_req === 1'b1) req_cycles++;
    expectWord("load-done", fetch_w);
    checkOutput();
    checkValue("load-pc", pc, 8'h02);
    checkValue("load-req-cycles", 8'(req_cycles), 8'd4);

    // Store at pc=02 with zero-wait ack
    imem_data = mem_i(1'b1, 3'd0, 3'd3, 3'd5);
    imem_ack  = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    expectWord("store-exec", w(0, 0, 0, 3'd0, 3'd3, 3'd5, 4'h0, 8'h00, 0, 0, 0, 0));
    checkOutput();
    @(negedge clk);
    dmem_ack = 1'b1;
    #1;
    expectWord("store-mem", w(0, 0, 0, 3'd0, 3'd3, 3'd5, 4'h0, 8'h00, 1, 1, 0, 0));
    checkOutput();
    @(negedge clk);
    dmem_ack = 1'b0;
    expectWord("store-done", fetch_w);
    checkOutput();
    checkValue("store-pc", pc, 8'h03);

    // Load at pc=03 abandoned by reset while waiting for dmem_ack
    imem_data = mem_i(1'b0, 3'd7, 3'd1, 3'd0);
    imem_ack  = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    expectWord("abort-exec", w(0, 0, 1, 3'd7, 3'd1, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0));
    checkOutput();
    repeat (2) begin
      @(negedge clk);
      expectWord("abort-wait", w(0, 0, 1, 3'd7, 3'd1, 3'd0, 4'h0, 8'h00, 1, 0, 0, 0));
      checkOutput();
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expectWord("abort-reset", fetch_w);
    checkOutput();
    checkValue("abort-pc", pc, 8'h00);
    dmem_ack = 1'b1;
    #1;
    expectWord("abort-late-ack", fetch_w);
    checkOutput();
    dmem_ack = 1'b0;

    // HALT at pc=00; stray acks must not wake it
    imem_data = flow_i(2'b11, 3'd5, 8'h00);
    imem_ack  = 1'b1;
    @(negedge clk);
    expectWord("halt-exec", w(0, 0, 0, 3'd0, 3'd5, 3'd0, 4'h0, 8'h00, 0, 0, 0, 0));
    checkOutput();
    dmem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expectWord($sformatf("halt-idle%0d", i), halt_w);
      checkOutput();
    end
    checkValue("halt-pc", pc, 8'h01);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;

    doReset();
    expectWord("halt-reset", fetch_w);
    checkOutput();
    checkValue("halt-reset-pc", pc, 8'h00);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard-leftover: got %0d pending, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
